// File: rtl/wall_collision_scanner.sv
// wall_collision_scanner: once per frame, walks every wall one per clock through a
// single shared rectangle-overlap comparator against the player bounding box and
// reports a sticky collision flag, the lowest hit wall index and the hit count.
// Optional macro WALL_COLLIDE_MARGIN_EN shrinks the player box by HIT_MARGIN per side.
module wall_collision_scanner #(
  parameter int WALL_NUM   = 10,
  parameter int WALL_W     = 20,
  parameter int WALL_H     = 60,
  parameter int PLAYER_W   = 16,
  parameter int PLAYER_H   = 16,
  parameter int HIT_MARGIN = 2
) (
  input  logic                    pixel_clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    clear_hit,
  input  logic [10:0]             player_x,
  input  logic [10:0]             player_y,
  input  logic [11*WALL_NUM-1:0]  wall_x_flat,
  input  logic [11*WALL_NUM-1:0]  wall_y_flat,
  output logic                    busy,
  output logic                    scan_done,
  output logic                    collision,
  output logic [7:0]              hit_index,
  output logic [7:0]              hit_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(WALL_NUM - 1);

`ifdef WALL_COLLIDE_MARGIN_EN
  localparam int MARGIN = HIT_MARGIN;
`else
  // Full player box; the margin parameter has no effect in this build.
  localparam int MARGIN = 0 * HIT_MARGIN;
`endif

  localparam logic [11:0] WALL_W12 = 12'(WALL_W);
  localparam logic [11:0] WALL_H12 = 12'(WALL_H);
  localparam logic [11:0] X_LO     = 12'(MARGIN);
  localparam logic [11:0] X_HI     = 12'(PLAYER_W - MARGIN);
  localparam logic [11:0] Y_LO     = 12'(MARGIN);
  localparam logic [11:0] Y_HI     = 12'(PLAYER_H - MARGIN);

  // Strict half-open overlap in 12 bits so coordinate sums never wrap; touching edges miss.
  function automatic logic overlap(input logic [10:0] px_i, input logic [10:0] py_i,
                                   input logic [10:0] wx_i, input logic [10:0] wy_i);
    logic [11:0] pxe, pye, wxe, wye;
    pxe = {1'b0, px_i};
    pye = {1'b0, py_i};
    wxe = {1'b0, wx_i};
    wye = {1'b0, wy_i};
    return ((pxe + X_LO) < (wxe + WALL_W12)) && (wxe < (pxe + X_HI)) &&
           ((pye + Y_LO) < (wye + WALL_H12)) && (wye < (pye + Y_HI));
  endfunction

  logic [1:0]  state;
  logic [7:0]  idx;
  logic [7:0]  cnt;
  logic        first_vld;
  logic [7:0]  first_idx;
  logic        done_hit;
  logic [10:0] px, py;
  logic [10:0] wx_cur, wy_cur;
  logic        hit_now;
  logic [7:0]  cnt_nxt;
  logic [7:0]  first_nxt;
  logic        last_check;

  assign wx_cur     = wall_x_flat[11*idx +: 11];
  assign wy_cur     = wall_y_flat[11*idx +: 11];
  assign hit_now    = (state == S_CHECK) && overlap(px, py, wx_cur, wy_cur);
  assign cnt_nxt    = cnt + 8'(hit_now);
  assign first_nxt  = first_vld ? first_idx : idx;
  assign last_check = (state == S_CHECK) && (idx == LAST_IDX);
  assign busy       = (state != S_IDLE);

  // Player snapshot taken once per scan; pure data, so no reset.
  always_ff @(posedge pixel_clk) begin
    if (state == S_LATCH) begin
      px <= player_x;
      py <= player_y;
    end
  end

  // Scan FSM, running accumulators and result registers.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
      done_hit  <= 1'b0;
      scan_done <= 1'b0;
      collision <= 1'b0;
      hit_index <= '0;
      hit_count <= '0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_tick) state <= S_LATCH;
        end
        S_LATCH: begin
          idx       <= '0;
          cnt       <= '0;
          first_vld <= 1'b0;
          state     <= S_CHECK;
        end
        S_CHECK: begin
          idx <= idx + 8'd1;
          cnt <= cnt_nxt;
          if (hit_now && !first_vld) begin
            first_vld <= 1'b1;
            first_idx <= idx;
          end
          // Results land on the same edge that raises scan_done.
          if (last_check) begin
            state     <= S_DONE;
            scan_done <= 1'b1;
            hit_count <= cnt_nxt;
            done_hit  <= (cnt_nxt != 8'd0);
            if (cnt_nxt != 8'd0) hit_index <= first_nxt;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // A hit being reported (set edge or the DONE cycle itself) beats a clear.
      if (last_check && (cnt_nxt != 8'd0))
        collision <= 1'b1;
      else if (clear_hit && !((state == S_DONE) && done_hit))
        collision <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wall_collision_scanner.sv
// tb_wall_collision_scanner: directed and randomized scans of wall_collision_scanner
// compared against a rectangle-intersection reference model.
module tb_wall_collision_scanner;

  localparam int WN = 10;
  localparam int WW = 20;
  localparam int WH = 60;
  localparam int PW = 16;
  localparam int PH = 16;
  localparam int HM = 2;
`ifdef WALL_COLLIDE_MARGIN_EN
  localparam int MEFF = HM;
`else
  localparam int MEFF = 0;
`endif

  logic              pixel_clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic              clear_hit = 1'b0;
  logic [10:0]       player_x = '0;
  logic [10:0]       player_y = '0;
  logic [11*WN-1:0]  wall_x_flat = '0;
  logic [11*WN-1:0]  wall_y_flat = '0;
  logic              busy, scan_done, collision;
  logic [7:0]        hit_index, hit_count;

  int n_chk = 0;
  int n_pass = 0;

  int pxv, pyv;
  int wx [WN];
  int wy [WN];

  // Reference state: what the outputs should currently show.
  int m_coll = 0;
  int m_idx  = 0;
  int m_cnt  = 0;

  wall_collision_scanner #(
    .WALL_NUM(WN), .WALL_W(WW), .WALL_H(WH),
    .PLAYER_W(PW), .PLAYER_H(PH), .HIT_MARGIN(HM)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .frame_tick(frame_tick), .clear_hit(clear_hit),
    .player_x(player_x), .player_y(player_y),
    .wall_x_flat(wall_x_flat), .wall_y_flat(wall_y_flat),
    .busy(busy), .scan_done(scan_done), .collision(collision),
    .hit_index(hit_index), .hit_count(hit_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic apply_inputs();
    player_x = 11'(pxv);
    player_y = 11'(pyv);
    for (int k = 0; k < WN; k++) begin
      wall_x_flat[11*k +: 11] = 11'(wx[k]);
      wall_y_flat[11*k +: 11] = 11'(wy[k]);
    end
  endtask

  task automatic set_far_walls();
    for (int k = 0; k < WN; k++) begin
      wx[k] = 500;
      wy[k] = 100;
    end
  endtask

  // Rectangle intersection of the (possibly shrunk) player box with each wall box.
  task automatic model_scan(output int cnt, output int first);
    int ax0, ax1, ay0, ay1;
    ax0 = pxv + MEFF;  ax1 = pxv + PW - MEFF;
    ay0 = pyv + MEFF;  ay1 = pyv + PH - MEFF;
    cnt = 0;
    first = -1;
    for (int k = 0; k < WN; k++) begin
      if (ax0 < wx[k] + WW && wx[k] < ax1 && ay0 < wy[k] + WH && wy[k] < ay1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_coll"}, int'(collision), m_coll);
    chk({tag, "_idx"},  int'(hit_index), m_idx);
    chk({tag, "_cnt"},  int'(hit_count), m_cnt);
  endtask

  task automatic run_scan(input string tag, input bit clr_at_done, input bit retick);
    int n, cnt, first, dones;
    apply_inputs();
    model_scan(cnt, first);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n = 1;
    chk({tag, "_busy_start"}, int'(busy), 1);
    while (!scan_done && n < 100) begin
      if (retick && n == 5) frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      n++;
    end
    chk({tag, "_latency"}, n, WN + 2);
    chk({tag, "_busy_done"}, int'(busy), 1);
    m_cnt = cnt;
    if (cnt > 0) begin
      m_coll = 1;
      m_idx = first;
    end
    check_outputs(tag);
    if (clr_at_done) begin
      clear_hit = 1'b1;
      tick();
      clear_hit = 1'b0;
      if (cnt == 0) m_coll = 0;
      chk({tag, "_coll_clr_done"}, int'(collision), m_coll);
    end else begin
      tick();
    end
    chk({tag, "_done_pulse"}, int'(scan_done), 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
    if (retick) begin
      dones = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (scan_done || busy) dones++;
      end
      chk({tag, "_no_requeue"}, dones, 0);
    end
  endtask

  initial begin
    int c, f;
    set_far_walls();
    pxv = 100;
    pyv = 100;
    apply_inputs();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(scan_done), 0);
    check_outputs("rst");
    reset = 1'b0;
    tick();

    run_scan("nohit", 1'b0, 1'b0);

    wx[3] = 110; wy[3] = 90;
    run_scan("single", 1'b0, 1'b0);

    set_far_walls();
    wx[2] = 116; wy[2] = 100;
    run_scan("edge116", 1'b0, 1'b0);
    wx[2] = 115;
    run_scan("edge115", 1'b0, 1'b0);
    wx[2] = 113;
    run_scan("edge113", 1'b0, 1'b0);

    set_far_walls();
    wx[4] = 105; wy[4] = 105;
    wx[7] = 95;  wy[7] = 80;
    run_scan("multi", 1'b0, 1'b0);
    clear_hit = 1'b1;
    tick();
    clear_hit = 1'b0;
    m_coll = 0;
    check_outputs("clear_idle");
    run_scan("clr_vs_set", 1'b1, 1'b0);

    run_scan("retick", 1'b0, 1'b1);

    // Reset six cycles into a scan aborts it.
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int i = 1; i < 6; i++) tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    m_coll = 0; m_idx = 0; m_cnt = 0;
    tick(); tick(); tick();
    chk("abort_done", int'(scan_done), 0);
    check_outputs("abort");
    reset = 1'b0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (scan_done || busy) c++;
    end
    chk("abort_quiet", c, 0);

    // Randomized scans with walls clustered near the player, some far off-screen.
    for (int it = 0; it < 24; it++) begin
      pxv = int'($urandom_range(0, 1900));
      pyv = int'($urandom_range(0, 1900));
      for (int k = 0; k < WN; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          wx[k] = int'($urandom_range(640, 2047));
          wy[k] = int'($urandom_range(0, 2047));
        end else begin
          wx[k] = pxv + int'($urandom_range(0, 50)) - 25;
          wy[k] = pyv + int'($urandom_range(0, 100)) - 70;
          if (wx[k] < 0) wx[k] = 0;
          if (wy[k] < 0) wy[k] = 0;
        end
      end
      model_scan(c, f);
      run_scan("rand", 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
